// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr
//   Registered priority encoder with a fixed-priority or round-robin mode.
//   A higher request index has higher fixed priority. In round-robin mode
//   the scan starts at an internal pointer and runs downward with wrap, so
//   the grant rotates through the active requests.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req        : request vector, bit i is request i
//   rr_en      : 1 = round-robin, 0 = fixed priority (highest index wins)
//   out_ready  : downstream ready
//   out_valid  : registered grant valid
//   out_idx    : registered binary index of the grant
//   out_onehot : registered one-hot grant (0 when not valid)
//   idle       : combinational, ~out_valid & ~|req
module prio_encoder_rr #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 rr_en,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [$clog2(N)-1:0] out_idx,
  output logic [N-1:0]         out_onehot,
  output logic                 idle
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_nxt;
  logic          load;
  logic          any_req;
  logic [IW-1:0] win;
  logic [N-1:0]  win_oh;

  assign load    = ~out_valid | out_ready;
  assign any_req = |req;
  assign idle    = ~out_valid & ~any_req;

  // The pointer update from an accepted grant is applied before the scan,
  // so a load in the same cycle as an accept already skips past the index
  // just accepted; this is what makes back-to-back rotation bubble-free.
  always_comb begin
    ptr_nxt = ptr;
    if (out_valid && out_ready && rr_en) begin
      if (out_idx == '0) ptr_nxt = IW'(N - 1);
      else               ptr_nxt = out_idx - IW'(1);
    end
  end

  // Round-robin picks the set request with the smallest downward distance
  // from the pointer (wrapping modulo N, never through unused codes).
  always_comb begin
    int unsigned p;
    int unsigned d;
    int unsigned best_d;
    win    = '0;
    win_oh = '0;
    p      = 32'(ptr_nxt);
    best_d = N;
    d      = 0;
    if (rr_en) begin
      for (int unsigned i = 0; i < N; i++) begin
        d = (p >= i) ? (p - i) : (p + N - i);
        if (req[i] && (d < best_d)) begin
          best_d = d;
          win    = IW'(i);
        end
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (req[i]) win = IW'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      win_oh[i] = any_req && (win == IW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      ptr        <= IW'(N - 1);
    end else begin
      ptr <= ptr_nxt;
      if (load) begin
        out_valid  <= any_req;
        out_idx    <= any_req ? win : '0;
        out_onehot <= win_oh;
      end
    end
  end

endmodule

// File: doc/prio_encoder_rr.md
PRIO_ENCODER_RR -- requirements
Module: prio_encoder_rr

Interface
REQ-001 The block SHALL provide parameter N, default 8, meaning the number of request inputs (legal range 2..64, power of two not required).
REQ-002 The block SHALL derive localparam IW = $clog2(N), meaning the index width.
REQ-003 Port clk  input  1  is the single clock; all state SHALL be updated on its rising edge.
REQ-004 Port rst_n  input  1: reset is asynchronous and active-low.
REQ-005 Port req  input  N  is the request vector; bit i is request i, and a higher index has higher fixed priority.
REQ-006 Port rr_en  input  1  selects round-robin arbitration when 1 and fixed priority when 0.
REQ-007 Port out_ready  input  1  is the downstream ready signal.
REQ-008 Port out_valid  output  1  is the registered grant-valid signal.
REQ-009 Port out_idx  output  IW  is the registered binary index of the granted request.
REQ-010 Port out_onehot  output  N  is the registered one-hot grant, equal to 1 << out_idx when valid and 0 otherwise.
REQ-011 Port idle  output  1  is combinational and SHALL equal ~out_valid & ~|req.

Function
REQ-012 load = ~out_valid | out_ready; the output register SHALL update only when load=1.
REQ-013 When load=1 and req!=0, the block SHALL set out_valid=1, out_idx=winner and out_onehot=1<<winner at the next edge, giving 1-cycle latency from req to out_valid.
REQ-014 When load=1 and req==0, the block SHALL set out_valid=0, out_idx=0 and out_onehot=0 at the next edge.
REQ-015 While out_valid=1 and out_ready=0 (stall), out_valid, out_idx and out_onehot SHALL hold regardless of req or rr_en changes.
REQ-016 When rr_en=0, winner SHALL be the highest set index of req.
REQ-017 When rr_en=1, winner SHALL be the first set index found scanning downward from ptr: ptr, ptr-1, ..., 0, N-1, ..., ptr+1.
REQ-018 ptr is an internal IW-bit pointer whose legal values are 0..N-1 only; wrap from 0 SHALL go to N-1, not to 2^IW-1.
REQ-019 On an accepted grant (out_valid & out_ready) with rr_en=1, the block SHALL set ptr to out_idx-1, or to N-1 when out_idx=0.
REQ-020 On an accepted grant with rr_en=0, ptr SHALL hold.
REQ-021 A change of rr_en SHALL take effect at the next load only, never on a stalled output.
REQ-022 Accept and new load in the same cycle SHALL be supported back-to-back, with no bubble when req stays non-zero and out_ready=1.
REQ-023 A request deasserting while its grant is stalled SHALL NOT retract the grant; the grant SHALL be held until accepted.
REQ-024 The block SHALL perform no request masking or storage beyond the single output register.

Reset
REQ-025 On rst_n=0, the block SHALL immediately (asynchronously) set out_valid=0, out_idx=0, out_onehot=0 and ptr=N-1.
REQ-026 Reset asserted mid-stall SHALL discard the held grant.
REQ-027 The first cycle after reset SHALL be a load cycle.
REQ-028 With ptr=N-1 after reset, the first round-robin grant SHALL equal the fixed-priority grant.

Verification
REQ-029 Reset and idle: assert rst_n=0 with req=0 -> out_valid=0, out_idx=0, out_onehot=0, idle=1; then set req=8'h01 -> idle=0 immediately and out_idx=0 valid one cycle later.
REQ-030 Fixed priority: N=8, rr_en=0, req=8'hA5, out_ready=1 -> every cycle out_valid=1, out_idx=7, out_onehot=8'h80.
REQ-031 Round-robin sweep: N=8, rr_en=1, req=8'hFF held, out_ready=1 -> out_idx sequence 7,6,5,4,3,2,1,0,7 with no bubbles.
REQ-032 Stall hold: a grant with out_idx=5 is held while out_ready=0 for 4 cycles as req changes to 8'h80 and then 0 -> out_idx stays 5; after out_ready=1 the next cycle gives out_valid=0 (req=0) or out_idx=7 (req=8'h80).
REQ-033 Non-power-of-two wrap: N=5, rr_en=1, req=5'b01001 -> out_idx sequence 3,0,3,0 and out_idx never exceeds 4.
REQ-034 Async reset mid-operation: rr_en=1 with ptr=2, stalled with out_idx=2, then pulse rst_n low between edges -> outputs are 0 immediately; after release, req=8'hFF gives out_idx=7.
